// File: rtl/bicintp_ctrl.sv
// bicintp_ctrl: frame sequencer for the bicubic datapath. Walks the destination
// raster in 12.8 fixed point, issues 4x4 line-buffer taps plus coefficient ROM
// reads per pixel, and emits intp_enb in unbroken 4-cycle groups.
module bicintp_ctrl #(
  parameter int AW = 12,
  parameter int PB = 6
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          start,
  input  logic [AW-1:0] cfg_src_w,
  input  logic [AW-1:0] cfg_src_h,
  input  logic [AW-1:0] cfg_dst_w,
  input  logic [AW-1:0] cfg_dst_h,
  input  logic [15:0]   cfg_step_x,
  input  logic [15:0]   cfg_step_y,
  input  logic [AW-1:0] line_avail,
  input  logic          out_afull,
  output logic          busy,
  output logic          frame_done,
  output logic [PB-1:0] coef_phase,
  output logic [1:0]    coef_tap,
  input  logic [7:0]    coef_w,
  output logic          ram_rd_en,
  output logic [AW-1:0] ram_col,
  output logic [AW-1:0] ram_row_0,
  output logic [AW-1:0] ram_row_1,
  output logic [AW-1:0] ram_row_2,
  output logic [AW-1:0] ram_row_3,
  output logic          intp_enb,
  output logic [7:0]    w_x,
  output logic [7:0]    w_y_0,
  output logic [7:0]    w_y_1,
  output logic [7:0]    w_y_2,
  output logic [7:0]    w_y_3
);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW_WAIT, S_WY_LOAD, S_PIX_CHK, S_PIX_RUN, S_ROW_END, S_DONE
  } state_t;

  localparam logic signed [AW+1:0] ONE = {{(AW+1){1'b0}}, 1'b1};

  state_t        state, state_nx;
  logic [AW-1:0] src_w_r, src_h_r, dst_w_r, dst_h_r;
  logic [15:0]   step_x_r, step_y_r;
  logic [AW+7:0] sx, sy;
  logic [AW-1:0] ox, oy;
  logic [1:0]    tap;
  logic          wy_ld_v;
  logic [1:0]    wy_ld_k;
  logic          cfg_load, pix_adv, row_adv;

  logic [AW-1:0] x_int, y_int;
  logic [PB-1:0] ph_x, ph_y;
  logic [AW:0]   y_plus2, h_minus1, need_row;
  logic          rows_ready, last_px, last_row;
  logic          unused_frac;

  assign x_int = sx[AW+7:8];
  assign y_int = sy[AW+7:8];
  assign ph_x  = sx[7 -: PB];
  assign ph_y  = sy[7 -: PB];
  assign unused_frac = ^{sx[7-PB:0], sy[7-PB:0]};

  // Row k of the window needs source row min(y_int+2, src_h-1) to be present.
  assign y_plus2    = {1'b0, y_int} + {{(AW-1){1'b0}}, 2'b10};
  assign h_minus1   = {1'b0, src_h_r} - {{AW{1'b0}}, 1'b1};
  assign need_row   = (y_plus2 < h_minus1) ? y_plus2 : h_minus1;
  assign rows_ready = ({1'b0, line_avail} > need_row);
  assign last_px    = (ox == dst_w_r - {{(AW-1){1'b0}}, 1'b1});
  assign last_row   = (oy == dst_h_r - {{(AW-1){1'b0}}, 1'b1});

  // ROM data is already registered by the ROM, so it lines up with intp_enb.
  assign w_x = intp_enb ? coef_w : '0;

  // Clamp base-1+off into [0, size-1] using a signed compare.
  function automatic logic [AW-1:0] clamp_tap(input logic [AW-1:0] base,
                                              input logic [1:0]    off,
                                              input logic [AW-1:0] size);
    logic signed [AW+1:0] pos, lim;
    pos = $signed({2'b00, base}) + $signed({{AW{1'b0}}, off}) - ONE;
    lim = $signed({2'b00, size}) - ONE;
    if (pos[AW+1])       clamp_tap = '0;
    else if (pos > lim)  clamp_tap = lim[AW-1:0];
    else                 clamp_tap = pos[AW-1:0];
  endfunction

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state decode, tap issue outputs and datapath strobes.
  always_comb begin
    state_nx   = state;
    cfg_load   = 1'b0;
    pix_adv    = 1'b0;
    row_adv    = 1'b0;
    ram_rd_en  = 1'b0;
    coef_phase = '0;
    coef_tap   = '0;
    ram_col    = '0;
    ram_row_0  = '0;
    ram_row_1  = '0;
    ram_row_2  = '0;
    ram_row_3  = '0;
    case (state)
      S_IDLE: begin
        if (start) begin
          cfg_load = 1'b1;
          state_nx = (cfg_dst_w == '0 || cfg_dst_h == '0) ? S_DONE : S_ROW_WAIT;
        end
      end
      S_ROW_WAIT: if (rows_ready) state_nx = S_WY_LOAD;
      S_WY_LOAD: begin
        coef_phase = ph_y;
        coef_tap   = tap;
        if (tap == 2'd3) state_nx = S_PIX_CHK;
      end
      S_PIX_CHK: if (!out_afull) state_nx = S_PIX_RUN;
      S_PIX_RUN: begin
        ram_rd_en  = 1'b1;
        coef_phase = ph_x;
        coef_tap   = tap;
        ram_col    = clamp_tap(x_int, tap, src_w_r);
        ram_row_0  = clamp_tap(y_int, 2'd0, src_h_r);
        ram_row_1  = clamp_tap(y_int, 2'd1, src_h_r);
        ram_row_2  = clamp_tap(y_int, 2'd2, src_h_r);
        ram_row_3  = clamp_tap(y_int, 2'd3, src_h_r);
        if (tap == 2'd3) begin
          pix_adv = 1'b1;
          if (last_px)        state_nx = S_ROW_END;
          else if (out_afull) state_nx = S_PIX_CHK;
        end
      end
      S_ROW_END: begin
        row_adv  = 1'b1;
        state_nx = last_row ? S_DONE : S_ROW_WAIT;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Config latch, coordinate accumulators, tap counter, weights and flags.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      src_w_r <= '0; src_h_r <= '0; dst_w_r <= '0; dst_h_r <= '0;
      step_x_r <= '0; step_y_r <= '0;
      sx <= '0; sy <= '0; ox <= '0; oy <= '0;
      tap <= '0; wy_ld_v <= 1'b0; wy_ld_k <= '0;
      w_y_0 <= '0; w_y_1 <= '0; w_y_2 <= '0; w_y_3 <= '0;
      intp_enb <= 1'b0; busy <= 1'b0; frame_done <= 1'b0;
    end else begin
      // Tap wraps 3->0, so back-to-back pixels need no extra reload.
      if (state == S_WY_LOAD || state == S_PIX_RUN) tap <= tap + 2'd1;
      else                                          tap <= '0;
      if (cfg_load) begin
        src_w_r  <= cfg_src_w;  src_h_r  <= cfg_src_h;
        dst_w_r  <= cfg_dst_w;  dst_h_r  <= cfg_dst_h;
        step_x_r <= cfg_step_x; step_y_r <= cfg_step_y;
        sx <= '0; sy <= '0; ox <= '0; oy <= '0;
      end
      if (pix_adv) begin
        sx <= sx + {{(AW-8){1'b0}}, step_x_r};
        ox <= ox + {{(AW-1){1'b0}}, 1'b1};
      end
      if (row_adv) begin
        sy <= sy + {{(AW-8){1'b0}}, step_y_r};
        oy <= oy + {{(AW-1){1'b0}}, 1'b1};
        sx <= '0;
        ox <= '0;
      end
      wy_ld_v <= (state == S_WY_LOAD);
      wy_ld_k <= tap;
      if (wy_ld_v) begin
        case (wy_ld_k)
          2'd0:    w_y_0 <= coef_w;
          2'd1:    w_y_1 <= coef_w;
          2'd2:    w_y_2 <= coef_w;
          default: w_y_3 <= coef_w;
        endcase
      end
      intp_enb   <= ram_rd_en;
      frame_done <= (state == S_DONE);
      if (cfg_load)             busy <= 1'b1;
      else if (state == S_DONE) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bicintp_ctrl.sv
// tb_bicintp_ctrl: directed and randomized frames against a raster-walk model
// computed with multiplication, plus a registered coefficient ROM model.
module tb_bicintp_ctrl;
  localparam int AW = 12;
  localparam int PB = 6;
  localparam int LIMIT = 20000;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_src_w = '0, cfg_src_h = '0, cfg_dst_w = '0, cfg_dst_h = '0;
  logic [15:0]   cfg_step_x = '0, cfg_step_y = '0;
  logic [AW-1:0] line_avail = '0;
  logic          out_afull = 1'b0;
  logic          busy, frame_done, ram_rd_en, intp_enb;
  logic [PB-1:0] coef_phase;
  logic [1:0]    coef_tap;
  logic [7:0]    coef_w = '0;
  logic [AW-1:0] ram_col, ram_row_0, ram_row_1, ram_row_2, ram_row_3;
  logic [7:0]    w_x, w_y_0, w_y_1, w_y_2, w_y_3;

  bicintp_ctrl #(.AW(AW), .PB(PB)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start),
    .cfg_src_w(cfg_src_w), .cfg_src_h(cfg_src_h),
    .cfg_dst_w(cfg_dst_w), .cfg_dst_h(cfg_dst_h),
    .cfg_step_x(cfg_step_x), .cfg_step_y(cfg_step_y),
    .line_avail(line_avail), .out_afull(out_afull),
    .busy(busy), .frame_done(frame_done),
    .coef_phase(coef_phase), .coef_tap(coef_tap), .coef_w(coef_w),
    .ram_rd_en(ram_rd_en), .ram_col(ram_col),
    .ram_row_0(ram_row_0), .ram_row_1(ram_row_1),
    .ram_row_2(ram_row_2), .ram_row_3(ram_row_3),
    .intp_enb(intp_enb), .w_x(w_x),
    .w_y_0(w_y_0), .w_y_1(w_y_1), .w_y_2(w_y_2), .w_y_3(w_y_3)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int col; int r0; int r1; int r2; int r3; int phx; int tap; int phy;
  } iss_t;

  iss_t exp_q[$];
  int   wx_q[$];
  int   tests = 0, fails = 0;
  int   cyc = 0, start_cyc = 0;
  int   rd_cnt = 0, enb_cnt = 0, run_len = 0, first_rd = -1;
  bit   mon_en = 1'b0;
  iss_t mon_e;

  function automatic logic [7:0] rom_f(input int ph, input int tp);
    return 8'((ph * 37 + tp * 91 + 5) & 255);
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Expected tap stream: pixel (ox,oy) sits at source (ox*step_x, oy*step_y).
  task automatic build_frame(input int sw, sh, dw, dh, stx, sty);
    exp_q.delete();
    wx_q.delete();
    for (int oy = 0; oy < dh; oy++) begin
      for (int ox = 0; ox < dw; ox++) begin
        int sxv, syv, xi, yi;
        iss_t e;
        sxv = (ox * stx) % (1 << 20);
        syv = (oy * sty) % (1 << 20);
        xi  = sxv / 256;
        yi  = syv / 256;
        for (int t = 0; t < 4; t++) begin
          e.col = clampi(xi - 1 + t, sw - 1);
          e.r0  = clampi(yi - 1, sh - 1);
          e.r1  = clampi(yi,     sh - 1);
          e.r2  = clampi(yi + 1, sh - 1);
          e.r3  = clampi(yi + 2, sh - 1);
          e.phx = (sxv % 256) >> (8 - PB);
          e.phy = (syv % 256) >> (8 - PB);
          e.tap = t;
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, {busy, frame_done, intp_enb, ram_rd_en}, 0);
    chk({tag, "_col"},  ram_col, 0);
    chk({tag, "_r01"},  {ram_row_0, ram_row_1}, 0);
    chk({tag, "_r23"},  {ram_row_2, ram_row_3}, 0);
    chk({tag, "_coef"}, {coef_phase, coef_tap, w_x}, 0);
    chk({tag, "_wy"},   {w_y_0, w_y_1, w_y_2, w_y_3}, 0);
  endtask

  // Synchronous coefficient ROM: data one cycle after the address.
  always @(posedge sys_clk) coef_w <= rom_f(int'(coef_phase), int'(coef_tap));

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: every tap issue against the model, w_x on intp_enb, group lengths.
  always @(negedge sys_clk) begin
    if (mon_en && !sys_rst) begin
      if (ram_rd_en === 1'b1) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        chk("rd_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("ram_col",    ram_col,    mon_e.col);
          chk("ram_row_0",  ram_row_0,  mon_e.r0);
          chk("ram_row_1",  ram_row_1,  mon_e.r1);
          chk("ram_row_2",  ram_row_2,  mon_e.r2);
          chk("ram_row_3",  ram_row_3,  mon_e.r3);
          chk("coef_phase", coef_phase, mon_e.phx);
          chk("coef_tap",   coef_tap,   mon_e.tap);
          chk("w_y_0", w_y_0, rom_f(mon_e.phy, 0));
          chk("w_y_1", w_y_1, rom_f(mon_e.phy, 1));
          chk("w_y_2", w_y_2, rom_f(mon_e.phy, 2));
          chk("w_y_3", w_y_3, rom_f(mon_e.phy, 3));
          wx_q.push_back(int'(rom_f(mon_e.phx, mon_e.tap)));
        end
      end
      if (intp_enb === 1'b1) begin
        enb_cnt++;
        run_len++;
        chk("enb_expected", 32'(wx_q.size() != 0), 1);
        if (wx_q.size() != 0) chk("w_x", w_x, wx_q.pop_front());
      end else if (run_len != 0) begin
        chk("group_len_mod4", run_len % 4, 0);
        run_len = 0;
      end
    end
  end

  // mode: 0 plain, 1 random afull, 2 start while busy, 3 afull at tap 1,
  //       4 line gating, 5 reset at tap 1 (returns with reset held)
  task automatic run_frame(input int sw, sh, dw, dh, stx, sty, la, mode);
    bit done, hit;
    int prev_busy, bp_state, bp_n, bp_cnt;
    build_frame(sw, sh, dw, dh, stx, sty);
    enb_cnt = 0; rd_cnt = 0; first_rd = -1;
    done = 0; hit = 0; bp_state = 0; bp_n = 0; bp_cnt = 0;
    cfg_src_w = AW'(sw); cfg_src_h = AW'(sh);
    cfg_dst_w = AW'(dw); cfg_dst_h = AW'(dh);
    cfg_step_x = 16'(stx); cfg_step_y = 16'(sty);
    line_avail = AW'(la); out_afull = 1'b0;
    @(posedge sys_clk); #1 start = 1'b1;
    @(posedge sys_clk); #1 start = 1'b0;
    start_cyc = cyc;
    chk("busy_after_start", busy, 1);
    prev_busy = 1;
    for (int n = 1; n <= LIMIT; n++) begin
      @(posedge sys_clk); #1;
      case (mode)
        1: out_afull = ($urandom_range(0, 2) == 0);
        2: begin
          if (n == 10) begin
            cfg_dst_w = AW'(1); cfg_dst_h = AW'(1);
            cfg_step_x = 16'($urandom); cfg_step_y = 16'($urandom);
            start = 1'b1;
          end else if (n == 11) start = 1'b0;
        end
        3: begin
          if (bp_state == 0 && ram_rd_en === 1'b1 && coef_tap == 2'd1) begin
            out_afull = 1'b1; bp_state = 1;
          end else if (bp_state == 1) begin
            bp_n++;
            if (ram_rd_en === 1'b1) bp_cnt++;
            if (bp_n == 12) begin
              chk("bp_group_tail", bp_cnt, 2);
              out_afull = 1'b0; bp_state = 2;
            end
          end
        end
        4: begin
          if (n == 50)  line_avail = AW'(3);
          if (n == 120) line_avail = AW'(sh);
        end
        5: begin
          if (ram_rd_en === 1'b1 && coef_tap == 2'd1) begin
            mon_en = 1'b0;
            sys_rst = 1'b1;
            #1 chk_zero("rst_async");
            hit = 1;
            break;
          end
        end
        default: ;
      endcase
      if (frame_done === 1'b1) begin
        done = 1;
        chk("busy_with_done", busy, 0);
        chk("busy_before_done", prev_busy, 1);
        break;
      end
      prev_busy = int'(busy);
    end
    out_afull = 1'b0;
    if (mode == 5) begin
      chk("rst_hit", hit, 1);
      return;
    end
    chk("frame_done_seen", done, 1);
    @(posedge sys_clk); #1;
    chk("done_pulse_width", frame_done, 0);
    chk("enb_count", enb_cnt, 4 * dw * dh);
    chk("exp_q_drained", exp_q.size(), 0);
    chk("wx_q_drained", wx_q.size(), 0);
    if (mode == 3) chk("bp_seen", bp_state, 2);
    if (mode == 4) chk("gate_first_rd", 32'((first_rd - start_cyc) >= 51), 1);
  endtask

  initial begin
    int sw, sh, dw, dh, enb_seen;
    repeat (3) @(posedge sys_clk);
    #1 chk_zero("reset");
    sys_rst = 1'b0;
    mon_en = 1'b1;

    // 2x2 from 4x4 at step 2.0
    run_frame(4, 4, 2, 2, 16'h0200, 16'h0200, 4, 0);
    // fractional step 1.25: phase and weight path
    run_frame(8, 8, 4, 2, 16'h0140, 16'h0100, 8, 0);
    // line gating
    run_frame(8, 8, 2, 2, 16'h0100, 16'h0100, 1, 4);
    // backpressure arriving mid-group
    run_frame(8, 8, 4, 1, 16'h0100, 16'h0100, 8, 3);

    // zero-width frame
    build_frame(1, 1, 0, 0, 0, 0);
    rd_cnt = 0;
    cfg_src_w = AW'(4); cfg_src_h = AW'(4);
    cfg_dst_w = '0; cfg_dst_h = AW'(3);
    @(posedge sys_clk); #1 start = 1'b1;
    @(posedge sys_clk); #1 start = 1'b0;
    chk("zs_busy", busy, 1);
    chk("zs_done_early", frame_done, 0);
    @(posedge sys_clk); #1;
    chk("zs_done", frame_done, 1);
    chk("zs_busy_low", busy, 0);
    @(posedge sys_clk); #1;
    chk("zs_done_width", frame_done, 0);
    repeat (3) @(posedge sys_clk);
    #1 chk("zs_no_rd", rd_cnt, 0);

    // start while busy is ignored
    run_frame(6, 6, 3, 2, 16'h0180, 16'h00c0, 6, 2);

    // randomized frames with random backpressure
    repeat (6) begin
      sw = $urandom_range(1, 20);
      sh = $urandom_range(1, 20);
      dw = $urandom_range(1, 6);
      dh = $urandom_range(1, 5);
      run_frame(sw, sh, dw, dh, $urandom_range(16'h0040, 16'h0300),
                $urandom_range(16'h0040, 16'h0300), sh, 1);
    end

    // reset mid-group
    run_frame(8, 8, 4, 4, 16'h0100, 16'h0100, 8, 5);
    exp_q.delete();
    wx_q.delete();
    run_len = 0;
    @(posedge sys_clk); #1 chk_zero("rst_hold");
    sys_rst = 1'b0;
    enb_seen = 0;
    repeat (20) begin
      @(posedge sys_clk); #1;
      if (intp_enb !== 1'b0 || busy !== 1'b0) enb_seen++;
    end
    chk("rst_quiet", enb_seen, 0);
    mon_en = 1'b1;
    run_frame(4, 4, 2, 2, 16'h0200, 16'h0200, 4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
